// File: rtl/md_unit_pkg.sv
// md_unit_pkg: op codes, FSM states and op-class helpers for the multiply/divide unit
package md_unit_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_e;

   typedef enum logic {IDLE, RUN} state_e;

   function automatic logic is_mul(input logic [2:0] op);
      return op == MDU_MULT || op == MDU_MULTU;
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return op == MDU_DIV || op == MDU_DIVU;
   endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle signed/unsigned multiply/divide into HI/LO with direct HI/LO writes
import md_unit_pkg::*;

module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       MDUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   state_e             state, state_n;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   hi_p, lo_p;
   logic               we_p, go, load, commit, mul, sgn_m, na, nb;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   ma, dv, q, r, quo, rem;

   assign mul   = is_mul(MDUOp);
   assign sgn_m = MDUOp == MDU_MULT;
   // one 2W multiplier serves both flavours: sign- or zero-extend operands, product low 2W bits are exact
   assign prod  = {{WIDTH{sgn_m & A[WIDTH-1]}}, A} * {{WIDTH{sgn_m & B[WIDTH-1]}}, B};
   // signed divide via magnitudes so -2^(W-1)/-1 wraps to 0x80..0 naturally and never traps
   assign na    = MDUOp == MDU_DIV && A[WIDTH-1];
   assign nb    = MDUOp == MDU_DIV && B[WIDTH-1];
   assign ma    = na ? -A : A;
   assign dv    = B == '0 ? WIDTH'(1) : (nb ? -B : B);
   assign q     = ma / dv;
   assign r     = ma % dv;
   assign quo   = (na ^ nb) ? -q : q;
   assign rem   = na ? -r : r;
   assign busy  = state == RUN;

   // next-state and control strobes; starts are only honoured in IDLE
   always_comb begin
      go      = state == IDLE && start;
      load    = go && (mul || is_div(MDUOp));
      commit  = state == RUN && cnt == CW'(1);
      state_n = load ? RUN : commit ? IDLE : state;
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // cycle counter, pending result capture and HI/LO architectural update
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         hi_p <= '0;
         lo_p <= '0;
         we_p <= 1'b0;
         HI   <= '0;
         LO   <= '0;
      end else begin
         cnt <= load ? CW'(mul ? MULT_CYCLES : DIV_CYCLES) : busy ? cnt - CW'(1) : cnt;
         if (load) begin
            hi_p <= mul ? prod[2*WIDTH-1:WIDTH] : rem;
            lo_p <= mul ? prod[WIDTH-1:0] : quo;
            we_p <= mul || B != '0;
         end
         if (commit && we_p)              HI <= hi_p;
         else if (go && MDUOp == MDU_MTHI) HI <= A;
         if (commit && we_p)              LO <= lo_p;
         else if (go && MDUOp == MDU_MTLO) LO <= A;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized scoreboard bench for md_unit against an arithmetic reference model
module tb_md_unit;
   import md_unit_pkg::*;

   localparam int NM = 5;
   localparam int ND = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0, b = '0;
   logic        busy;
   logic [31:0] hi, lo;

   md_unit #(.WIDTH(32), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
      .clk(clk), .reset(reset), .start(start), .MDUOp(op),
      .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_chk = 0, n_fail = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [31:0] c_hi = '0, c_lo = '0;
   logic        acc_mt = 1'b0;
   bit          prev_busy = 0, was_rst = 0;
   int          run = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // reference model: update architectural HI/LO from plain arithmetic and queue the expectation
   task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit go);
      longint sq, sr;
      exp_t   t;
      if (go) begin
         case (o)
            MDU_MULT:  begin sq = longint'($signed(x)) * longint'($signed(y)); {m_hi, m_lo} = sq; end
            MDU_MULTU: {m_hi, m_lo} = {32'b0, x} * {32'b0, y};
            MDU_DIV:   if (y != 0) begin
                          sq = longint'($signed(x)) / longint'($signed(y));
                          sr = longint'($signed(x)) % longint'($signed(y));
                          m_lo = sq[31:0];
                          m_hi = sr[31:0];
                       end
            MDU_DIVU:  if (y != 0) begin m_lo = x / y; m_hi = x % y; end
            MDU_MTHI:  m_hi = x;
            MDU_MTLO:  m_lo = x;
            default:   ;
         endcase
         if (o != MDU_NONE) begin
            t.hi  = m_hi;
            t.lo  = m_lo;
            t.len = (o == MDU_MULT || o == MDU_MULTU) ? NM : (o == MDU_DIV || o == MDU_DIVU) ? ND : 0;
            sb.push_back(t);
         end
      end
      start = go;
      op    = o;
      a     = x;
      b     = y;
      step();
      start = 1'b0;
      op    = 3'($urandom_range(0, 6));
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 40) begin
         step();
         k++;
      end
      if (busy) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout: got busy=1 after 40 cycles expected busy=0");
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      launch(o, x, y, 1'b1);
      wait_idle();
   endtask

   // note which edges accepted a direct HI/LO write so the monitor knows a result is due
   always @(posedge clk) acc_mt <= start && !busy && !reset && (op == MDU_MTHI || op == MDU_MTLO);

   // monitor: result on busy falling or after an accepted MT; HI/LO must hold while busy
   always @(negedge clk) begin
      if (reset) begin
         c_hi      = '0;
         c_lo      = '0;
         run       = 0;
         prev_busy = 0;
         was_rst   = 1;
      end else begin
         if (was_rst) begin
            check("reset_hi", hi, 32'h0);
            check("reset_lo", lo, 32'h0);
            check("reset_busy", {31'b0, busy}, 32'h0);
            was_rst = 0;
         end
         if (busy) begin
            run++;
            check("hold_hi", hi, c_hi);
            check("hold_lo", lo, c_lo);
         end else if (prev_busy || acc_mt) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_result: got hi=%h lo=%h expected no result", hi, lo);
            end else begin
               e = sb.pop_front();
               check("busy_len", run, e.len);
               check("hi", hi, e.hi);
               check("lo", lo, e.lo);
               c_hi = e.hi;
               c_lo = e.lo;
            end
            run = 0;
         end
         prev_busy = busy;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  o;
      logic [31:0] x, y;
      bit          g;
      repeat (3) step();
      reset = 1'b0;
      step();
      issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      issue(MDU_DIVU, 32'd7, 32'd2);
      issue(MDU_MTHI, 32'h0000_1234, 32'd0);
      issue(MDU_DIV, 32'd5, 32'd0);
      issue(MDU_DIVU, 32'd9, 32'd0);
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(MDU_MTLO, 32'hCAFE_F00D, 32'd0);
      launch(MDU_MTHI, 32'h1111_1111, 32'd0, 1'b0);
      launch(MDU_NONE, 32'h2222_2222, 32'd0, 1'b1);
      // MULT with an MTLO start landing on its second busy cycle
      launch(MDU_MULT, 32'h0001_0003, 32'hFFFF_0005, 1'b1);
      step();
      start = 1'b1;
      op    = MDU_MTLO;
      a     = 32'hDEAD_BEEF;
      step();
      start = 1'b0;
      wait_idle();
      // reset on the third busy cycle of a DIV aborts it for good
      launch(MDU_DIV, 32'd1000, 32'd7, 1'b1);
      step();
      step();
      reset = 1'b1;
      sb.delete();
      m_hi = '0;
      m_lo = '0;
      step();
      reset = 1'b0;
      repeat (15) step();
      check("abort_hi", hi, m_hi);
      check("abort_lo", lo, m_lo);
      check("abort_busy", {31'b0, busy}, 32'h0);
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom_range(0, 6));
         x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0:       y = 32'd0;
            1:       y = 32'hFFFF_FFFF;
            2:       y = 32'($urandom_range(1, 9));
            default: y = $urandom;
         endcase
         g = $urandom_range(0, 7) != 0;
         issue(o, x, y);
         if (!g) launch(3'($urandom_range(1, 6)), $urandom, $urandom, 1'b0);
      end
      repeat (3) step();
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
